regfile_wr_arbiter: RTL and testbench

- Shares the single write port of the register_file (wr/rw/d/en_n) among NUM_REQ writeback requesters, e.g. ALU writeback and load writeback.
- Uses a round-robin arbiter with valid/ready handshakes on the requester side.
- Output to the register file is registered: one write per cycle, one-cycle latency.
- Discards writes to register $0 and keeps a saturating count of committed writes.

---
 rtl/regfile_wr_arbiter_if.sv | 45 ++++
 rtl/regfile_wr_arbiter.sv | 126 ++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/regfile_wr_arbiter_if.sv
// regfile_wr_arbiter_if
//   Bundles the requester handshake, the register_file write port and the
//   status outputs of regfile_wr_arbiter.
//   slave  : the arbiter (drives req_ready, rf_*, wr_count, busy)
//   master : the environment (drives stall, req_valid, req_addr, req_data)
//   Signals:
//     stall      stall request, blocks all grants while 1
//     req_valid  per-requester valid
//     req_addr   packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//     req_data   packed data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//     req_ready  one-hot grant
//     rf_en_n    register_file enable, active-low
//     rf_wr      register_file write enable
//     rf_rw      register_file write address
//     rf_d       register_file write data
//     wr_count   saturating committed-write count
//     busy       any request pending or write in flight
interface regfile_wr_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                          stall;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          rf_en_n;
  logic                          rf_wr;
  logic [ADDR_WIDTH-1:0]         rf_rw;
  logic [DATA_WIDTH-1:0]         rf_d;
  logic [CNT_WIDTH-1:0]          wr_count;
  logic                          busy;

  modport slave (
    input  stall, req_valid, req_addr, req_data,
    output req_ready, rf_en_n, rf_wr, rf_rw, rf_d, wr_count, busy
  );

  modport master (
    output stall, req_valid, req_addr, req_data,
    input  req_ready, rf_en_n, rf_wr, rf_rw, rf_d, wr_count, busy
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//   Shares the single register_file write port among NUM_REQ writeback
//   requesters. Round-robin grant with valid/ready handshake, registered
//   write port (one write per cycle, one-cycle latency), writes to
//   register 0 are accepted but dropped, and committed writes are counted
//   with saturation.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-low reset
//     bus  regfile_wr_arbiter_if.slave (handshake, rf write port, status)
//   Build option:
//     RF_ARB_FIXED_PRIO_EN  when defined, lowest valid index always wins and
//                           no round-robin pointer is kept.
module regfile_wr_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wr_arbiter_if.slave bus
);
  localparam int unsigned IDXW = $clog2(NUM_REQ);

  logic                  en_n_q;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] rw_q, rw_d;
  logic [DATA_WIDTH-1:0] d_q, d_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    gnt;
  logic [IDXW-1:0]       gnt_idx;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

`ifndef RF_ARB_FIXED_PRIO_EN
  logic [IDXW-1:0]       last_gnt_q, last_gnt_d;
`endif

  // Grant search: first valid index starting after the last grant
  // (or from index 0 in fixed-priority builds).
  always_comb begin
    int unsigned idx;
    logic        found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    if (!bus.stall && !en_n_q) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef RF_ARB_FIXED_PRIO_EN
        idx = k;
`else
        idx = (32'(last_gnt_q) + 32'd1 + k) % NUM_REQ;
`endif
        if (!found && bus.req_valid[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          gnt_idx  = IDXW'(idx);
        end
      end
    end
  end

  assign xfer     = |(gnt & bus.req_valid);
  assign sel_addr = bus.req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_data = bus.req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    wr_d  = 1'b0;
    rw_d  = rw_q;
    d_d   = d_q;
    cnt_d = cnt_q;
    if (xfer) begin
      rw_d = sel_addr;
      d_d  = sel_data;
      // Register 0 is hard-wired: complete the handshake but never write.
      wr_d = (sel_addr != '0);
    end
    if (wr_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

`ifndef RF_ARB_FIXED_PRIO_EN
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (xfer) begin
      last_gnt_d = gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt_q <= IDXW'(NUM_REQ - 1);
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_n_q <= 1'b1;
      wr_q   <= 1'b0;
      rw_q   <= '0;
      d_q    <= '0;
      cnt_q  <= '0;
    end else begin
      en_n_q <= 1'b0;
      wr_q   <= wr_d;
      rw_q   <= rw_d;
      d_q    <= d_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.rf_en_n   = en_n_q;
  assign bus.rf_wr     = wr_q;
  assign bus.rf_rw     = rw_q;
  assign bus.rf_d      = d_q;
  assign bus.wr_count  = cnt_q;
  assign bus.busy      = (|bus.req_valid) | wr_q;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  regfile_wr_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REQ(2), .CNT_WIDTH(16)) bus ();
  regfile_wr_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REQ(2), .CNT_WIDTH(4))  sbus ();

  regfile_wr_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REQ(2), .CNT_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  regfile_wr_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REQ(2), .CNT_WIDTH(4)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset for 5 cycles, release on a negedge, then step past the enabling edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.stall = 1'b0; bus.req_valid = 2'b01;
    bus.req_addr = {5'd0, 5'd27}; bus.req_data = {32'h0, 32'hdcaf484c};
    sbus.stall = 1'b0; sbus.req_valid = 2'b00; sbus.req_addr = '0; sbus.req_data = '0;
    repeat (5) @(negedge clk);
    n_cmp++; if (bus.rf_wr !== 1'b0) begin n_err++; $display("FAIL rst_rf_wr got=%b exp=0", bus.rf_wr); end
    n_cmp++; if (bus.rf_en_n !== 1'b1) begin n_err++; $display("FAIL rst_rf_en_n got=%b exp=1", bus.rf_en_n); end
    n_cmp++; if (bus.rf_rw !== 5'd0) begin n_err++; $display("FAIL rst_rf_rw got=%0d exp=0", bus.rf_rw); end
    n_cmp++; if (bus.rf_d !== 32'd0) begin n_err++; $display("FAIL rst_rf_d got=%h exp=0", bus.rf_d); end
    n_cmp++; if (bus.wr_count !== 16'd0) begin n_err++; $display("FAIL rst_wr_count got=%0d exp=0", bus.wr_count); end
    n_cmp++; if (bus.req_ready !== 2'b00) begin n_err++; $display("FAIL rst_req_ready got=%b exp=00", bus.req_ready); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.rf_en_n !== 1'b0) begin n_err++; $display("FAIL en_after_rst got=%b exp=0", bus.rf_en_n); end
    n_cmp++; if (bus.req_ready !== 2'b01) begin n_err++; $display("FAIL single_ready got=%b exp=01", bus.req_ready); end
    n_cmp++; if (bus.rf_wr !== 1'b0) begin n_err++; $display("FAIL single_no_early_wr got=%b exp=0", bus.rf_wr); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    n_cmp++; if (bus.rf_wr !== 1'b1) begin n_err++; $display("FAIL single_rf_wr got=%b exp=1", bus.rf_wr); end
    n_cmp++; if (bus.rf_rw !== 5'd27) begin n_err++; $display("FAIL single_rf_rw got=%0d exp=27", bus.rf_rw); end
    n_cmp++; if (bus.rf_d !== 32'hdcaf484c) begin n_err++; $display("FAIL single_rf_d got=%h exp=dcaf484c", bus.rf_d); end
    n_cmp++; if (bus.wr_count !== 16'd0) begin n_err++; $display("FAIL single_cnt_pre got=%0d exp=0", bus.wr_count); end
    @(negedge clk);
    n_cmp++; if (bus.wr_count !== 16'd1) begin n_err++; $display("FAIL single_cnt got=%0d exp=1", bus.wr_count); end
    n_cmp++; if (bus.rf_wr !== 1'b0) begin n_err++; $display("FAIL single_wr_drop got=%b exp=0", bus.rf_wr); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_rdy [4];
    logic [4:0] exp_rw  [4];
    exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_rw  = '{5'd4, 5'd8, 5'd4, 5'd8};
    do_reset();
    bus.req_addr = {5'd8, 5'd4};
    bus.req_data = {32'h11111111, 32'h37373737};
    bus.req_valid = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.req_ready !== exp_rdy[i]) begin n_err++; $display("FAIL contend_ready[%0d] got=%b exp=%b", i, bus.req_ready, exp_rdy[i]); end
      @(negedge clk);
      n_cmp++; if (bus.rf_wr !== 1'b1) begin n_err++; $display("FAIL contend_wr[%0d] got=%b exp=1", i, bus.rf_wr); end
      n_cmp++; if (bus.rf_rw !== exp_rw[i]) begin n_err++; $display("FAIL contend_rw[%0d] got=%0d exp=%0d", i, bus.rf_rw, exp_rw[i]); end
    end
    n_cmp++; if (bus.rf_d !== 32'h11111111) begin n_err++; $display("FAIL contend_d got=%h exp=11111111", bus.rf_d); end
    bus.req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_zero_reg();
    n_cmp++; if (bus.wr_count !== 16'd4) begin n_err++; $display("FAIL zero_cnt_start got=%0d exp=4", bus.wr_count); end
    bus.req_valid = 2'b10;
    bus.req_addr = {5'd0, 5'd3};
    bus.req_data = {32'hffffffff, 32'h0badf00d};
    #1;
    n_cmp++; if (bus.req_ready !== 2'b10) begin n_err++; $display("FAIL zero_ready got=%b exp=10", bus.req_ready); end
    @(negedge clk);
    n_cmp++; if (bus.rf_wr !== 1'b0) begin n_err++; $display("FAIL zero_rf_wr got=%b exp=0", bus.rf_wr); end
    bus.req_addr = {5'd9, 5'd3};
    bus.req_valid = 2'b11;
    #1;
    n_cmp++; if (bus.req_ready !== 2'b01) begin n_err++; $display("FAIL zero_next_ready got=%b exp=01", bus.req_ready); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL busy_hi got=%b exp=1", bus.busy); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    n_cmp++; if (bus.wr_count !== 16'd4) begin n_err++; $display("FAIL zero_cnt_hold got=%0d exp=4", bus.wr_count); end
    n_cmp++; if (bus.rf_wr !== 1'b1) begin n_err++; $display("FAIL zero_next_wr got=%b exp=1", bus.rf_wr); end
    n_cmp++; if (bus.rf_rw !== 5'd3) begin n_err++; $display("FAIL zero_next_rw got=%0d exp=3", bus.rf_rw); end
    @(negedge clk);
    n_cmp++; if (bus.wr_count !== 16'd5) begin n_err++; $display("FAIL zero_cnt_after got=%0d exp=5", bus.wr_count); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL busy_lo got=%b exp=0", bus.busy); end
  endtask

  task automatic test_stall();
    bus.stall = 1'b1;
    bus.req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (bus.req_ready !== 2'b00) begin n_err++; $display("FAIL stall_ready[%0d] got=%b exp=00", i, bus.req_ready); end
      @(negedge clk);
      n_cmp++; if (bus.rf_wr !== 1'b0) begin n_err++; $display("FAIL stall_wr[%0d] got=%b exp=0", i, bus.rf_wr); end
    end
    bus.stall = 1'b0;
    #1;
    n_cmp++; if (bus.req_ready !== 2'b10) begin n_err++; $display("FAIL stall_resume_ready got=%b exp=10", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    n_cmp++; if (bus.rf_rw !== 5'd9 || bus.rf_wr !== 1'b1) begin n_err++; $display("FAIL stall_resume_wr got=%b/%0d exp=1/9", bus.rf_wr, bus.rf_rw); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    bus.req_valid = 2'b11;
    #1;
    n_cmp++; if (bus.req_ready !== 2'b01) begin n_err++; $display("FAIL ar_pre_ready got=%b exp=01", bus.req_ready); end
    @(negedge clk);
    n_cmp++; if (bus.rf_wr !== 1'b1) begin n_err++; $display("FAIL ar_inflight got=%b exp=1", bus.rf_wr); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.rf_wr !== 1'b0) begin n_err++; $display("FAIL ar_wr_async got=%b exp=0", bus.rf_wr); end
    n_cmp++; if (bus.rf_en_n !== 1'b1) begin n_err++; $display("FAIL ar_en_async got=%b exp=1", bus.rf_en_n); end
    n_cmp++; if (bus.req_ready !== 2'b00) begin n_err++; $display("FAIL ar_ready_async got=%b exp=00", bus.req_ready); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.rf_wr !== 1'b0) begin n_err++; $display("FAIL ar_no_partial got=%b exp=0", bus.rf_wr); end
    n_cmp++; if (bus.req_ready !== 2'b01) begin n_err++; $display("FAIL ar_first_grant got=%b exp=01", bus.req_ready); end
    bus.req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    int exp_cnt;
    do_reset();
    sbus.req_addr = {5'd0, 5'd7};
    sbus.req_data = {32'h0, 32'h5a5a5a5a};
    sbus.req_valid = 2'b01;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 20) sbus.req_valid = 2'b00;
      exp_cnt = (k - 1 > 15) ? 15 : k - 1;
      n_cmp++; if (sbus.wr_count !== 4'(exp_cnt)) begin n_err++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", k, sbus.wr_count, exp_cnt); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_contention();
    test_zero_reg();
    test_stall();
    test_async_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
